// File: rtl/shift_operand_loader_pkg.sv
// shift_operand_loader_pkg: operand geometry and loader state encoding for the matrix arithmetic path
package shift_operand_loader_pkg;
    localparam int NUM_BITS  = 512;
    localparam int LANE_BITS = 8;
    localparam int BUS_BITS  = 64;
    localparam int BEATS     = NUM_BITS / BUS_BITS;
    localparam int CNT_BITS  = $clog2(BEATS);

    typedef enum logic [1:0] {IDLE, LOAD_DD, LOAD_AA, PRESENT} state_t;
endpackage

// File: rtl/shift_operand_loader_beat_deserializer.sv
// shift_operand_loader_beat_deserializer: BUS_BITS-wide writes into one NUM_BITS register, slot chosen by beat index
module shift_operand_loader_beat_deserializer
    import shift_operand_loader_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [CNT_BITS-1:0] idx,
    input  logic [BUS_BITS-1:0] din,
    output logic [NUM_BITS-1:0] q
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= '0;
        else if (we) q[idx*BUS_BITS +: BUS_BITS] <= din;
endmodule

// File: rtl/shift_operand_loader.sv
// shift_operand_loader: assembles dd/aa operands from a beat stream and hands them to the shifter
module shift_operand_loader
    import shift_operand_loader_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BUS_BITS-1:0] in_data,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NUM_BITS-1:0] out_dd,
    output logic [NUM_BITS-1:0] out_aa,
    output logic                frame_err
);
    state_t state, state_nx;
    logic [CNT_BITS-1:0] cnt, cnt_nx;
    logic acc, last_beat, bad;

    assign in_ready  = state == LOAD_DD || state == LOAD_AA;
    assign out_valid = state == PRESENT;
    assign acc       = in_valid && in_ready;
    assign last_beat = cnt == CNT_BITS'(BEATS - 1);
    // in_last must be set on exactly the final aa beat, nowhere else
    assign bad       = acc && (in_last != (state == LOAD_AA && last_beat));

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: state_nx = LOAD_DD;
            LOAD_DD, LOAD_AA: if (acc) begin
                cnt_nx = (last_beat || bad) ? '0 : cnt + 1'b1;
                if (bad) state_nx = LOAD_DD;
                else if (last_beat) state_nx = state == LOAD_DD ? LOAD_AA : PRESENT;
            end
            PRESENT: if (out_ready) state_nx = LOAD_DD;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            frame_err <= bad;
        end

    shift_operand_loader_beat_deserializer u_dd (
        .clk(clk), .rst_n(rst_n), .we(acc && state == LOAD_DD),
        .idx(cnt), .din(in_data), .q(out_dd)
    );

    shift_operand_loader_beat_deserializer u_aa (
        .clk(clk), .rst_n(rst_n), .we(acc && state == LOAD_AA),
        .idx(cnt), .din(in_data), .q(out_aa)
    );
endmodule

// File: doc/shift_operand_loader.md
Name: shift_operand_loader

Overview:
- Upstream feeder for the lane-wise vector shifter in the matrix arithmetic path.
- Assembles the 512-bit data operand (dd) and the 512-bit per-lane shift-amount operand (aa) from a narrow 64-bit beat stream.
- Presents the completed dd/aa pair to the shifter stage with a valid/ready handshake.
- Framing is checked; malformed frames are dropped and flagged.

Parameters:
- NUM_BITS, 512, operand width; integer multiple of BUS_BITS and LANE_BITS
- LANE_BITS, 8, lane width of the shifter
- BUS_BITS, 64, input beat width; BEATS = NUM_BITS/BUS_BITS (8 at defaults)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  loader can accept a beat
- in_data  in  BUS_BITS  beat payload
- in_last  in  1  marks the final beat of a frame
- out_valid  out  1  dd/aa pair complete
- out_ready  in  1  shifter stage consumes the pair
- out_dd  out  NUM_BITS  data operand to shifter
- out_aa  out  NUM_BITS  shift-amount operand to shifter
- frame_err  out  1  one-cycle pulse: malformed frame dropped

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, beat_cnt=0, out_dd=0, out_aa=0.
  - in_ready=0, out_valid=0, frame_err=0.
- Beat acceptance: a beat is accepted when in_valid && in_ready at a rising edge.
- Frame format: 2*BEATS beats.
  - Beats 0..BEATS-1 fill out_dd, beat k into bits [k*BUS_BITS +: BUS_BITS] (beat 0 = LSBs).
  - Beats BEATS..2*BEATS-1 fill out_aa the same way.
- States:
  - IDLE: entered only from reset; moves to LOAD_DD on the next cycle. in_ready=0.
  - LOAD_DD: in_ready=1. Accepted beat writes out_dd, beat_cnt++. After beat BEATS-1, beat_cnt wraps to 0 and state moves to LOAD_AA.
  - LOAD_AA: in_ready=1. Accepted beat writes out_aa, beat_cnt++. After beat BEATS-1, beat_cnt wraps to 0 and state moves to PRESENT.
  - PRESENT: out_valid=1, in_ready=0. out_dd/out_aa are held stable. When out_ready=1, out_valid drops next cycle and state moves to LOAD_DD.
- Latency: out_valid rises the cycle after the final accepted beat.
- Throughput: minimum 2*BEATS+1 cycles per pair; no overlap between presenting a pair and loading the next.
- in_valid bubbles: state and counters hold; no timeout.
- Framing check on each accepted beat:
  - Error if in_last=1 on any beat other than the final one (overall index 2*BEATS-1).
  - Error if in_last=0 on the final beat.
  - On error: frame_err=1 for exactly one cycle, beat_cnt=0, state=LOAD_DD, out_valid stays 0.
  - Partially written out_dd/out_aa bits are left as-is; they are don't-care while out_valid=0.
- out_dd/out_aa may change during loading; the consumer must qualify them with out_valid.
- Reset asserted mid-load or mid-PRESENT: the partial or pending pair is discarded and all outputs return to reset values immediately.
- out_ready while out_valid=0 is ignored.
- Lane contents are not interpreted; clamping of aa lanes >= LANE_BITS is the shifter's job.

Decomposition:
- Shared package (matrix arithmetic package) holds:
  - state enum {IDLE, LOAD_DD, LOAD_AA, PRESENT}
  - constants NUM_BITS, LANE_BITS, BUS_BITS, BEATS
  - beat-count width: clog2(BEATS)
- Sub-module: beat_deserializer, one BUS_BITS-to-NUM_BITS write-by-index register bank. It is instantiated twice (dd, aa) and enabled by state.
- FSM and framing check live in the top module.

Test Plan:
- Reset and startup: hold rst_n=0 for 3 cycles, release -> in_ready=0 in the first cycle after release, 1 in the second; all outputs 0.
- Basic frame: beat0=64'h43, beats1-7=0, beat8=64'h01, beats9-15=0, in_last on beat15 -> out_valid rises the cycle after beat15; out_dd={504'b0,8'h43}, out_aa={504'b0,8'h01}.
- Backpressure: after a full frame, hold out_ready=0 for 5 cycles -> out_valid stays 1, in_ready stays 0, out_dd/out_aa unchanged. Raise out_ready -> out_valid=0 and in_ready=1 next cycle.
- Mid-vector lane: beat4 of dd=64'h19<<48, beat12 (aa beat 4)=64'h04<<48, otherwise 0 -> out_dd[311:304]=8'h19, out_aa[311:304]=8'h04, all other bits 0.
- Framing error: in_last=1 on beat 5 -> frame_err one-cycle pulse, no out_valid. A following correct frame with aa lane 63 = 8'h09 -> out_aa[511:504]=8'h09.
- Reset mid-load: assert rst_n=0 after beat 10 -> out_valid=0, out_dd=0, out_aa=0. A full frame after release is delivered correctly.
